wide_proc_sequencer: RTL

//  Instruction sequencer for the 512-bit processor datapath (register file, ALU, memory).
//  - Buffers LOAD/STORE/ADD/MUL commands in a small FIFO.
//  - Issues each command as the exact per-cycle pattern on the processor control inputs
//    (reg_select, mem_address, ALU_Control, control, mem_to_reg_enable, mem_to_reg).
//  - Hides the registered register-file and memory read latencies.
//  - Reports completion, errors and a retired-instruction count.

---
 rtl/wide_proc_pkg.sv | 31 +++
 rtl/wide_proc_sequencer_if.sv | 40 ++++
 rtl/wide_instr_fifo.sv | 49 ++++
 rtl/wide_proc_sequencer.sv | 116 +++++++++++
 4 files changed

// File: rtl/wide_proc_pkg.sv
// Shared types for the wide-datapath instruction sequencer: opcodes, FSM states, queued command.
package wide_proc_pkg;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_MUL   = 2'b11;

  localparam int CMD_W = 13;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_XFER     = 3'd2,
    ST_ALU_WAIT = 3'd3,
    ST_ALU_WB   = 3'd4,
    ST_RETIRE   = 3'd5
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] rsel;
    logic [8:0] addr;
  } cmd_t;

  // LOAD and STORE are the only opcodes that touch memory.
  function automatic logic is_mem_op(input logic [1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/wide_proc_sequencer_if.sv
// Command intake, processor control outputs and status of the wide-datapath sequencer.
interface wide_proc_sequencer_if #(
  parameter int CNT_W = 16
);
  import wide_proc_pkg::*;

  // A command is transferred on any rising edge where instr_valid && instr_ready;
  // instr_ready depends only on registered FIFO state, never on instr_valid.
  logic             instr_valid;
  logic             instr_ready;
  logic [1:0]       instr_op;
  logic [1:0]       instr_reg;
  logic [8:0]       instr_addr;

  logic [1:0]       reg_select;
  logic [8:0]       mem_address;
  logic             ALU_Control;
  logic             control;
  logic             mem_to_reg_enable;
  logic             mem_to_reg;

  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] retired_count;
  state_t           dbg_state;

  modport master (
    output instr_valid, instr_op, instr_reg, instr_addr,
    input  instr_ready, reg_select, mem_address, ALU_Control, control,
           mem_to_reg_enable, mem_to_reg, busy, done, err, retired_count, dbg_state
  );

  modport slave (
    input  instr_valid, instr_op, instr_reg, instr_addr,
    output instr_ready, reg_select, mem_address, ALU_Control, control,
           mem_to_reg_enable, mem_to_reg, busy, done, err, retired_count, dbg_state
  );

endinterface

// File: rtl/wide_instr_fifo.sv
// Synchronous command FIFO; head entry is visible combinationally whenever not empty.
module wide_instr_fifo
  import wide_proc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  cmd_t wdata_i,
  input  logic pop_i,
  output cmd_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  cmd_t        mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/wide_proc_sequencer.sv
// Sequences queued LOAD/STORE/ADD/MUL commands into per-cycle control patterns for the
// 512-bit register/ALU/memory datapath, covering its registered read latencies.
module wide_proc_sequencer
  import wide_proc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  parameter int MAX_ADDR   = 496
) (
  input  logic                  clk,
  input  logic                  rst,
  wide_proc_sequencer_if.slave  bus
);

  state_t           state_q, state_d;
  cmd_t             cmd_q;
  logic [CNT_W-1:0] count_q;

  cmd_t fifo_head;
  cmd_t in_cmd;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic addr_bad;

  logic m2r_en;
  logic m2r;
  logic alu_wb;
  logic done_p;
  logic err_p;

  assign in_cmd = '{op: bus.instr_op, rsel: bus.instr_reg, addr: bus.instr_addr};
  assign push   = bus.instr_valid && !fifo_full;
  assign pop    = (state_q == ST_IDLE) && !fifo_empty;

  wide_instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (in_cmd),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A memory access window is 16 words, so the base must leave room for base+15.
  assign addr_bad = is_mem_op(cmd_q.op) && (cmd_q.addr > 9'(MAX_ADDR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (!fifo_empty) state_d = ST_SETUP;
      ST_SETUP: begin
        if (addr_bad)                    state_d = ST_IDLE;
        else if (is_mem_op(cmd_q.op))    state_d = ST_XFER;
        else                             state_d = ST_ALU_WAIT;
      end
      ST_XFER:     state_d = ST_RETIRE;
      ST_ALU_WAIT: state_d = ST_ALU_WB;
      ST_ALU_WB:   state_d = ST_RETIRE;
      ST_RETIRE:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Strobes decode straight from the state register so reset clears them at once.
  always_comb begin
    m2r_en = 1'b0;
    m2r    = 1'b0;
    alu_wb = 1'b0;
    done_p = 1'b0;
    err_p  = 1'b0;
    case (state_q)
      ST_SETUP:  err_p = addr_bad;
      ST_XFER: begin
        m2r_en = 1'b1;
        m2r    = (cmd_q.op == OP_LOAD);
      end
      ST_ALU_WB: alu_wb = 1'b1;
      ST_RETIRE: done_p = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q   <= '0;
      count_q <= '0;
    end else begin
      if (pop)                  cmd_q   <= fifo_head;
      if (state_q == ST_RETIRE) count_q <= count_q + 1'b1;
    end
  end

  // Address, register and ALU-op selects are simply the latched command, held until the next pop.
  assign bus.reg_select        = cmd_q.rsel;
  assign bus.mem_address       = cmd_q.addr;
  assign bus.control           = (cmd_q.op == OP_MUL);
  assign bus.mem_to_reg_enable = m2r_en;
  assign bus.mem_to_reg        = m2r;
  assign bus.ALU_Control       = alu_wb;
  assign bus.done              = done_p;
  assign bus.err               = err_p;
  assign bus.instr_ready       = !fifo_full;
  assign bus.busy              = (state_q != ST_IDLE) || !fifo_empty;
  assign bus.retired_count     = count_q;
  assign bus.dbg_state         = state_q;

endmodule
